// File: rtl/pc_score_counter_up.sv
// Computer-opponent score: a two-digit BCD up-counter that advances at a
// difficulty-selected rate and flags a win when it reaches the target score.
module pc_score_counter_up #(
    parameter int CNT_W       = 26,
    parameter int DIV_EASY    = 50000000,
    parameter int DIV_MED     = 25000000,
    parameter int DIV_HARD    = 12500000,
    parameter int TARGET_TENS = 3,
    parameter int TARGET_ONES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] level,
    input  logic       pause,
    input  logic       player_ended,
    output logic [3:0] q0,
    output logic [3:0] q1,
    output logic       ended,
    output logic       step,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] EASY_M1 = CNT_W'(DIV_EASY - 1);
    localparam logic [CNT_W-1:0] MED_M1  = CNT_W'(DIV_MED - 1);
    localparam logic [CNT_W-1:0] HARD_M1 = CNT_W'(DIV_HARD - 1);
    localparam logic [3:0]       T_TENS  = 4'(TARGET_TENS);
    localparam logic [3:0]       T_ONES  = 4'(TARGET_ONES);

    state_t           state_q, state_d;
    logic [3:0]       q0_q, q0_d;
    logic [3:0]       q1_q, q1_d;
    logic             ended_q, ended_d;
    logic             step_q, step_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [1:0]       level_q, level_d;

    logic [CNT_W-1:0] period_m1;
    logic [3:0]       q0_inc;
    logic [3:0]       q1_inc;
    logic             hit_target;

    // Period comes from the level latched at start, never the live input.
    always_comb begin
        period_m1 = HARD_M1;
        case (level_q)
            2'b00:   period_m1 = EASY_M1;
            2'b01:   period_m1 = MED_M1;
            default: period_m1 = HARD_M1;
        endcase
    end

    always_comb begin
        q0_inc = q0_q + 4'd1;
        q1_inc = q1_q;
        if (q0_q == 4'd9) begin
            q0_inc = 4'd0;
            q1_inc = q1_q + 4'd1;
        end
    end

    assign hit_target = (q1_inc == T_TENS) && (q0_inc == T_ONES);

    always_comb begin
        state_d = state_q;
        q0_d    = q0_q;
        q1_d    = q1_q;
        ended_d = ended_q;
        step_d  = 1'b0;
        div_d   = div_q;
        level_d = level_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    q0_d    = 4'd0;
                    q1_d    = 4'd0;
                    ended_d = 1'b0;
                    div_d   = '0;
                    level_d = level;
                end
            end
            ST_RUN: begin
                // A player finish outranks pause, which outranks a tick.
                if (player_ended) begin
                    state_d = ST_DONE;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (div_q == period_m1) begin
                    div_d  = '0;
                    q0_d   = q0_inc;
                    q1_d   = q1_inc;
                    step_d = 1'b1;
                    if (hit_target) begin
                        ended_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_PAUSED: begin
                if (player_ended) begin
                    state_d = ST_DONE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            q0_q    <= 4'd0;
            q1_q    <= 4'd0;
            ended_q <= 1'b0;
            step_q  <= 1'b0;
            div_q   <= '0;
            level_q <= 2'b00;
        end else begin
            state_q <= state_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            ended_q <= ended_d;
            step_q  <= step_d;
            div_q   <= div_d;
            level_q <= level_d;
        end
    end

    assign q0    = q0_q;
    assign q1    = q1_q;
    assign ended = ended_q;
    assign step  = step_q;
    assign state = state_q;

endmodule
